branch_resolve: RTL and testbench

Registered branch/jump resolution unit for the pipelined core. It consumes the ALU flags of the instruction in the Execute stage and decides whether the branch is taken. On a redirect it drives PC select and target into Fetch, then runs a flush sequence into the Decode and Execute pipeline registers. It also keeps branch/taken event counters for performance measurement.

---
 rtl/branch_pkg.sv | 25 ++
 rtl/branch_cond.sv | 38 +++
 rtl/branch_resolve.sv | 134 +++++++++++++
 tb/tb_branch_resolve.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared definitions for the branch resolution unit.
//   - RV32I branch Funct3 codes
//   - FSM state type
//   - helper telling whether a Funct3 code is a real conditional branch
package branch_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        FLUSH    = 2'd2
    } state_t;

    // 010/011 are not branch encodings; they never resolve taken and are not counted.
    function automatic logic f3_is_branch(input logic [2:0] f3);
        return (f3 != 3'b010) && (f3 != 3'b011);
    endfunction

endpackage

// File: rtl/branch_cond.sv
// Combinational branch condition evaluation.
// Ports:
//   funct3    in  3  branch condition code
//   zero_flag in  1  ALU result == 0
//   branch_e  in  1  conditional branch in Execute
//   jump_e    in  1  unconditional jump in Execute (wins over branch_e)
//   valid_br  out 1  a countable conditional branch is present
//   taken     out 1  control flow must be redirected
module branch_cond
    import branch_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       zero_flag,
    input  logic       branch_e,
    input  logic       jump_e,
    output logic       valid_br,
    output logic       taken
);

    logic cond;

    // Decode programs SUB for BEQ/BNE and SLT/SLTU for the ordered compares,
    // so Z=0 on the ordered compares means "less than" was true.
    always_comb begin
        cond = 1'b0;
        unique case (funct3)
            F3_BEQ:           cond = zero_flag;
            F3_BNE:           cond = ~zero_flag;
            F3_BLT, F3_BLTU:  cond = ~zero_flag;
            F3_BGE, F3_BGEU:  cond = zero_flag;
            default:          cond = 1'b0;
        endcase
    end

    assign valid_br = branch_e & ~jump_e & f3_is_branch(funct3);
    assign taken    = jump_e | (valid_br & cond);

endmodule

// File: rtl/branch_resolve.sv
// Registered branch/jump resolution unit.
// Decides taken/not-taken for the instruction in Execute, redirects Fetch one
// cycle later and holds FlushD/FlushE for FLUSH_CYCLES cycles (stretched by
// stalls). Keeps wrap-around counters of resolved branches and taken events.
// Ports:
//   clk, rst                 clock, async active-high reset
//   BranchE, JumpE           branch / jump in Execute
//   Funct3E, ZeroFlag        condition code and ALU zero flag
//   PCTargetE                resolved target
//   StallE                   Execute held; freezes this unit
//   PCSrc, PCTarget          Fetch redirect select and address
//   FlushD, FlushE, Busy     flush outputs / sequence in progress
//   BrCount, TakenCount      performance counters
//
// state    | meaning
// IDLE     | accepting resolve events
// REDIRECT | first redirect cycle: PCSrc and flushes high
// FLUSH    | remaining flush cycles, cnt_q counts down to 0
module branch_resolve
    import branch_pkg::*;
#(
    parameter int W            = 32,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             BranchE,
    input  logic             JumpE,
    input  logic [2:0]       Funct3E,
    input  logic             ZeroFlag,
    input  logic [W-1:0]     PCTargetE,
    input  logic             StallE,
    output logic             PCSrc,
    output logic [W-1:0]     PCTarget,
    output logic             FlushD,
    output logic             FlushE,
    output logic             Busy,
    output logic [CNT_W-1:0] BrCount,
    output logic [CNT_W-1:0] TakenCount
);

    localparam int CW = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES) : 1;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [W-1:0]     pc_target_q, pc_target_d;
    logic [CNT_W-1:0] br_count_q, br_count_d;
    logic [CNT_W-1:0] taken_count_q, taken_count_d;

    logic valid_br;
    logic taken;
    logic resolve;

    branch_cond u_cond (
        .funct3    (Funct3E),
        .zero_flag (ZeroFlag),
        .branch_e  (BranchE),
        .jump_e    (JumpE),
        .valid_br  (valid_br),
        .taken     (taken)
    );

    assign resolve = (state_q == IDLE) && !StallE && (BranchE || JumpE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            pc_target_q   <= '0;
            br_count_q    <= '0;
            taken_count_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            pc_target_q   <= pc_target_d;
            br_count_q    <= br_count_d;
            taken_count_q <= taken_count_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        pc_target_d   = pc_target_q;
        br_count_d    = br_count_q;
        taken_count_d = taken_count_q;

        // A stall freezes everything, so an asserted flush simply stays asserted.
        if (!StallE) begin
            unique case (state_q)
                IDLE: begin
                    if (resolve && taken) begin
                        state_d     = REDIRECT;
                        pc_target_d = PCTargetE;
                    end
                end
                REDIRECT: begin
                    if (FLUSH_CYCLES == 1) begin
                        state_d = IDLE;
                    end else begin
                        state_d = FLUSH;
                        cnt_d   = CW'(FLUSH_CYCLES - 2);
                    end
                end
                FLUSH: begin
                    if (cnt_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (resolve) begin
            br_count_d    = br_count_q + CNT_W'(valid_br);
            taken_count_d = taken_count_q + CNT_W'(taken);
        end
    end

    always_comb begin
        PCSrc  = (state_q == REDIRECT);
        FlushD = (state_q != IDLE);
        FlushE = (state_q != IDLE);
        Busy   = (state_q != IDLE);
    end

    assign PCTarget   = pc_target_q;
    assign BrCount    = br_count_q;
    assign TakenCount = taken_count_q;

endmodule

// File: tb/tb_branch_resolve.sv
module tb_branch_resolve;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        BranchE = 1'b0;
    logic        JumpE = 1'b0;
    logic [2:0]  Funct3E = 3'b000;
    logic        ZeroFlag = 1'b0;
    logic [31:0] PCTargetE = 32'h0;
    logic        StallE = 1'b0;

    // Instance a: FLUSH_CYCLES=1, CNT_W=32
    logic        a_ps, a_fd, a_fe, a_bz;
    logic [31:0] a_pt, a_bc, a_tc;
    // Instance b: FLUSH_CYCLES=3, CNT_W=32
    logic        b_ps, b_fd, b_fe, b_bz;
    logic [31:0] b_pt, b_bc, b_tc;
    // Instance c: FLUSH_CYCLES=1, CNT_W=4
    logic        c_ps, c_fd, c_fe, c_bz;
    logic [31:0] c_pt;
    logic [3:0]  c_bc, c_tc;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    branch_resolve #(.W(32), .FLUSH_CYCLES(1), .CNT_W(32)) u_a (
        .clk(clk), .rst(rst), .BranchE(BranchE), .JumpE(JumpE), .Funct3E(Funct3E),
        .ZeroFlag(ZeroFlag), .PCTargetE(PCTargetE), .StallE(StallE),
        .PCSrc(a_ps), .PCTarget(a_pt), .FlushD(a_fd), .FlushE(a_fe), .Busy(a_bz),
        .BrCount(a_bc), .TakenCount(a_tc));

    branch_resolve #(.W(32), .FLUSH_CYCLES(3), .CNT_W(32)) u_b (
        .clk(clk), .rst(rst), .BranchE(BranchE), .JumpE(JumpE), .Funct3E(Funct3E),
        .ZeroFlag(ZeroFlag), .PCTargetE(PCTargetE), .StallE(StallE),
        .PCSrc(b_ps), .PCTarget(b_pt), .FlushD(b_fd), .FlushE(b_fe), .Busy(b_bz),
        .BrCount(b_bc), .TakenCount(b_tc));

    branch_resolve #(.W(32), .FLUSH_CYCLES(1), .CNT_W(4)) u_c (
        .clk(clk), .rst(rst), .BranchE(BranchE), .JumpE(JumpE), .Funct3E(Funct3E),
        .ZeroFlag(ZeroFlag), .PCTargetE(PCTargetE), .StallE(StallE),
        .PCSrc(c_ps), .PCTarget(c_pt), .FlushD(c_fd), .FlushE(c_fe), .Busy(c_bz),
        .BrCount(c_bc), .TakenCount(c_tc));

    // ---------------- behavioural model ----------------
    // rem: flush cycles still owed; first: the owed sequence has not advanced yet.
    int              m_fc [3] = '{1, 3, 1};
    int              m_cw [3] = '{32, 32, 4};
    int              m_rem [3] = '{0, 0, 0};
    bit              m_first [3] = '{0, 0, 0};
    logic [31:0]     m_tgt [3] = '{0, 0, 0};
    longint unsigned m_br [3] = '{0, 0, 0};
    longint unsigned m_tk [3] = '{0, 0, 0};

    function automatic bit spec_taken_cond(input logic [2:0] f3, input logic z);
        case (f3)
            3'b000, 3'b101, 3'b111: return z;
            3'b001, 3'b100, 3'b110: return !z;
            default:                return 1'b0;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                m_rem[i] = 0; m_first[i] = 0; m_tgt[i] = '0; m_br[i] = 0; m_tk[i] = 0;
            end else if (StallE) begin
                // frozen
            end else if (m_rem[i] > 0) begin
                m_rem[i]   = m_rem[i] - 1;
                m_first[i] = 0;
            end else if (JumpE || BranchE) begin
                bit is_br, tk;
                longint unsigned mask;
                mask  = (m_cw[i] >= 64) ? ~64'd0 : ((64'd1 << m_cw[i]) - 1);
                is_br = !JumpE && (Funct3E != 3'b010) && (Funct3E != 3'b011);
                tk    = JumpE || (is_br && spec_taken_cond(Funct3E, ZeroFlag));
                if (is_br) m_br[i] = (m_br[i] + 1) & mask;
                if (tk) begin
                    m_tk[i]    = (m_tk[i] + 1) & mask;
                    m_rem[i]   = m_fc[i];
                    m_first[i] = 1;
                    m_tgt[i]   = PCTargetE;
                end
            end
        end
    end

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cmp(input int i, input string tag, input logic ps, input logic [31:0] pt,
                       input logic fd, input logic fe, input logic bz,
                       input longint unsigned bc, input longint unsigned tc);
        bit fl;
        fl = (m_rem[i] > 0);
        chk({tag, ".PCSrc"},      longint'(ps), longint'(fl && m_first[i]));
        chk({tag, ".PCTarget"},   longint'(pt), longint'(m_tgt[i]));
        chk({tag, ".FlushD"},     longint'(fd), longint'(fl));
        chk({tag, ".FlushE"},     longint'(fe), longint'(fl));
        chk({tag, ".Busy"},       longint'(bz), longint'(fl));
        chk({tag, ".BrCount"},    bc, m_br[i]);
        chk({tag, ".TakenCount"}, tc, m_tk[i]);
    endtask

    always @(negedge clk) begin
        cmp(0, "a", a_ps, a_pt, a_fd, a_fe, a_bz, longint'(a_bc), longint'(a_tc));
        cmp(1, "b", b_ps, b_pt, b_fd, b_fe, b_bz, longint'(b_bc), longint'(b_tc));
        cmp(2, "c", c_ps, c_pt, c_fd, c_fe, c_bz, longint'(c_bc), longint'(c_tc));
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic b, input logic j, input logic [2:0] f3,
                         input logic z, input logic [31:0] t, input logic s);
        BranchE = b; JumpE = j; Funct3E = f3; ZeroFlag = z; PCTargetE = t; StallE = s;
    endtask

    task automatic idle();
        drive(0, 0, 3'b000, 0, 32'h0, 0);
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        cyc();
        rst = 1'b0;
        chk("reset.a_PCSrc", longint'(a_ps), 0);
        chk("reset.b_TakenCount", longint'(b_tc), 0);

        // BEQ taken, Z=1
        do_reset();
        drive(1, 0, 3'b000, 1, 32'h40, 0);
        cyc(); idle();
        chk("beq.PCSrc",    longint'(a_ps), 1);
        chk("beq.PCTarget", longint'(a_pt), 64'h40);
        chk("beq.FlushD",   longint'(a_fd), 1);
        chk("beq.FlushE",   longint'(a_fe), 1);
        chk("beq.BrCount",  longint'(a_bc), 1);
        chk("beq.Taken",    longint'(a_tc), 1);
        cyc();
        chk("beq.FlushD_end", longint'(a_fd), 0);
        chk("beq.PCSrc_end",  longint'(a_ps), 0);
        chk("beq.b_flush2",   longint'(b_fd), 1);
        cyc();
        chk("beq.b_flush3",   longint'(b_fd), 1);
        cyc();
        chk("beq.b_flush_end", longint'(b_fd), 0);

        // BNE not taken, then invalid funct3
        do_reset();
        drive(1, 0, 3'b001, 1, 32'h44, 0);
        cyc();
        drive(1, 0, 3'b010, 0, 32'h48, 0);
        cyc(); idle(); cyc();
        chk("bne.FlushD",  longint'(a_fd), 0);
        chk("bne.BrCount", longint'(a_bc), 1);
        chk("bne.Taken",   longint'(a_tc), 0);

        // JAL with wrong-path branches on the 3-cycle flush instance
        do_reset();
        drive(0, 1, 3'b000, 0, 32'h100, 0);
        cyc();
        drive(1, 0, 3'b000, 1, 32'h200, 0);
        chk("jal.b_PCSrc1", longint'(b_ps), 1);
        chk("jal.b_Flush1", longint'(b_fd), 1);
        cyc();
        chk("jal.b_PCSrc2", longint'(b_ps), 0);
        chk("jal.b_Flush2", longint'(b_fd), 1);
        cyc(); idle();
        chk("jal.b_Flush3", longint'(b_fe), 1);
        cyc();
        chk("jal.b_Flush4", longint'(b_fd), 0);
        chk("jal.b_Target", longint'(b_pt), 64'h100);
        chk("jal.b_Taken",  longint'(b_tc), 1);
        chk("jal.b_Br",     longint'(b_bc), 0);

        // BLTU taken with a 2-cycle stall in the flush
        do_reset();
        drive(1, 0, 3'b110, 0, 32'h80, 0);
        cyc();
        drive(0, 0, 3'b000, 0, 32'h0, 1);
        chk("bltu.Flush1", longint'(a_fd), 1);
        cyc();
        chk("bltu.Flush2", longint'(a_fd), 1);
        chk("bltu.PCSrc2", longint'(a_ps), 1);
        cyc();
        chk("bltu.Flush3", longint'(a_fd), 1);
        chk("bltu.Target", longint'(a_pt), 64'h80);
        idle();
        cyc();
        chk("bltu.Flush4", longint'(a_fd), 0);
        chk("bltu.Target_end", longint'(a_pt), 64'h80);

        // Async reset in the middle of a flush
        do_reset();
        drive(0, 1, 3'b000, 0, 32'h300, 0);
        cyc(); idle(); cyc();
        chk("rst.b_in_flush", longint'(b_fd), 1);
        #1 rst = 1'b1;
        #1;
        chk("rst.b_FlushD",   longint'(b_fd), 0);
        chk("rst.b_Busy",     longint'(b_bz), 0);
        chk("rst.b_PCTarget", longint'(b_pt), 0);
        chk("rst.b_Taken",    longint'(b_tc), 0);
        #2 rst = 1'b0;
        drive(1, 0, 3'b101, 1, 32'h500, 0);
        cyc(); idle();
        chk("rst.bge_PCSrc",  longint'(a_ps), 1);
        chk("rst.bge_Target", longint'(a_pt), 64'h500);
        chk("rst.bge_Br",     longint'(a_bc), 1);
        chk("rst.bge_Taken",  longint'(a_tc), 1);

        // 17 taken BGE: 4-bit counters wrap to 1
        do_reset();
        for (int k = 0; k < 17; k++) begin
            drive(1, 0, 3'b101, 1, 32'h600 + 32'(k), 0);
            cyc(); idle(); cyc();
        end
        chk("wrap.c_Taken", longint'(c_tc), 1);
        chk("wrap.c_Br",    longint'(c_bc), 1);
        chk("wrap.a_Taken", longint'(a_tc), 17);
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
